// File: rtl/seg_scan_if.sv
// Frame handshake and display-drive bundle for seg_scan_ctrl.
// The master side is the frame producer and display sink. The slave side is the scan controller.
interface seg_scan_if #(
  parameter int unsigned DIGITS = 6
);
  logic                  frame_valid;
  logic                  frame_ready;
  logic [4*DIGITS-1:0]   frame_data;
  logic [DIGITS-1:0]     frame_en;
  logic [3:0]            bin_data;
  logic                  seg_en;
  logic [DIGITS-1:0]     seg_sel;
  logic                  frame_done;

  modport master (
    output frame_valid, frame_data, frame_en,
    input  frame_ready, bin_data, seg_en, seg_sel, frame_done
  );

  modport slave (
    input  frame_valid, frame_data, frame_en,
    output frame_ready, bin_data, seg_en, seg_sel, frame_done
  );
endinterface

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed 7-segment scan controller with a 1-deep pending frame buffer.
// Optional inter-digit ghost blanking is enabled by defining SEG_GHOST_BLANK_EN.
module seg_scan_ctrl #(
  parameter int unsigned CLK_FREQ     = 50_000_000,
  parameter int unsigned SCAN_FREQ    = 1000,
  parameter int unsigned DIGITS       = 6,
  parameter int unsigned BLANK_CYCLES = 32
) (
  input  logic      clk,
  input  logic      rst_n,
  seg_scan_if.slave bus
);

  localparam int unsigned DWELL = CLK_FREQ / SCAN_FREQ;
  localparam int unsigned CW    = $clog2(DWELL);
  localparam int unsigned IW    = $clog2(DIGITS);
  localparam int unsigned FW    = 4 * DIGITS;

  if (DWELL < 2) begin : g_chk_dwell
    $error("seg_scan_ctrl: DWELL must be >= 2");
  end
  if (DIGITS < 2) begin : g_chk_digits
    $error("seg_scan_ctrl: DIGITS must be >= 2");
  end
  if (BLANK_CYCLES < 1) begin : g_chk_blank
    $error("seg_scan_ctrl: BLANK_CYCLES must be >= 1");
  end

`ifdef SEG_GHOST_BLANK_EN
  localparam int unsigned BW = $clog2(BLANK_CYCLES + 1);
  typedef enum logic [1:0] {IDLE, SHOW, BLANK} state_e;
  logic [BW-1:0] bcnt_q, bcnt_d;
`else
  typedef enum logic [0:0] {IDLE, SHOW} state_e;
`endif

  state_e            state_q, state_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              pend_full_q, pend_full_d;
  logic [FW-1:0]     pend_data_q, pend_data_d;
  logic [DIGITS-1:0] pend_en_q, pend_en_d;
  logic [FW-1:0]     act_data_q, act_data_d;
  logic [DIGITS-1:0] act_en_q, act_en_d;
  logic [3:0]        bin_q, bin_d;
  logic              seg_en_q, seg_en_d;
  logic [DIGITS-1:0] sel_q, sel_d;
  logic              ready_q, ready_d;
  logic              done_q, done_d;
  logic              accept;
  logic              slot_end;

  assign accept = bus.frame_valid & ready_q;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    pend_full_d = pend_full_q;
    pend_data_d = pend_data_q;
    pend_en_d   = pend_en_q;
    act_data_d  = act_data_q;
    act_en_d    = act_en_q;
    bin_d       = bin_q;
    seg_en_d    = 1'b0;
    sel_d       = '1;
    done_d      = 1'b0;
    slot_end    = 1'b0;
`ifdef SEG_GHOST_BLANK_EN
    bcnt_d      = bcnt_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          act_data_d = bus.frame_data;
          act_en_d   = bus.frame_en;
          idx_d      = '0;
          cnt_d      = '0;
          state_d    = SHOW;
        end
      end
      SHOW: begin
        if (cnt_q == CW'(DWELL - 1)) begin
          cnt_d = '0;
`ifdef SEG_GHOST_BLANK_EN
          bcnt_d  = '0;
          state_d = BLANK;
`else
          slot_end = 1'b1;
`endif
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`ifdef SEG_GHOST_BLANK_EN
      BLANK: begin
        if (bcnt_q == BW'(BLANK_CYCLES - 1)) begin
          slot_end = 1'b1;
          state_d  = SHOW;
        end else begin
          bcnt_d = bcnt_q + 1'b1;
        end
      end
`endif
      default: state_d = IDLE;
    endcase

    // Frame swap at the boundary happens before this cycle's accept, so a
    // frame arriving on the boundary lands in the (just emptied) pending slot.
    if (slot_end) begin
      if (idx_q == IW'(DIGITS - 1)) begin
        idx_d  = '0;
        done_d = 1'b1;
        if (pend_full_q) begin
          act_data_d  = pend_data_q;
          act_en_d    = pend_en_q;
          pend_full_d = 1'b0;
        end
      end else begin
        idx_d = idx_q + 1'b1;
      end
    end

    if (accept && (state_q != IDLE)) begin
      pend_data_d = bus.frame_data;
      pend_en_d   = bus.frame_en;
      pend_full_d = 1'b1;
    end

    ready_d = ~pend_full_d;

    // Outputs are registered from the next state so they line up with it.
    if (state_d == SHOW) begin
      bin_d        = act_data_d[{idx_d, 2'b00} +: 4];
      seg_en_d     = act_en_d[idx_d];
      sel_d[idx_d] = ~act_en_d[idx_d];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      cnt_q       <= '0;
      pend_full_q <= 1'b0;
      pend_data_q <= '0;
      pend_en_q   <= '0;
      act_data_q  <= '0;
      act_en_q    <= '0;
      bin_q       <= '0;
      seg_en_q    <= 1'b0;
      sel_q       <= '1;
      ready_q     <= 1'b1;
      done_q      <= 1'b0;
`ifdef SEG_GHOST_BLANK_EN
      bcnt_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      pend_full_q <= pend_full_d;
      pend_data_q <= pend_data_d;
      pend_en_q   <= pend_en_d;
      act_data_q  <= act_data_d;
      act_en_q    <= act_en_d;
      bin_q       <= bin_d;
      seg_en_q    <= seg_en_d;
      sel_q       <= sel_d;
      ready_q     <= ready_d;
      done_q      <= done_d;
`ifdef SEG_GHOST_BLANK_EN
      bcnt_q      <= bcnt_d;
`endif
    end
  end

  assign bus.frame_ready = ready_q;
  assign bus.bin_data    = bin_q;
  assign bus.seg_en      = seg_en_q;
  assign bus.seg_sel     = sel_q;
  assign bus.frame_done  = done_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Scoreboard bench for seg_scan_ctrl: accepted frames queue up in a timeline model
// and a negedge monitor compares every cycle of display output against it.
module tb_seg_scan_ctrl;

  localparam int unsigned DIGITS = 4;
  localparam int unsigned DWELL  = 10;
`ifdef SEG_GHOST_BLANK_EN
  localparam int unsigned BLANK  = 2;
`else
  localparam int unsigned BLANK  = 0;
`endif
  localparam int unsigned SLOT   = DWELL + BLANK;
  localparam int unsigned PERIOD = DIGITS * SLOT;

  typedef struct packed {
    logic [15:0] data;
    logic [3:0]  en;
  } frame_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  seg_scan_if #(.DIGITS(DIGITS)) bus ();

  seg_scan_ctrl #(
    .CLK_FREQ    (1000),
    .SCAN_FREQ   (100),
    .DIGITS      (DIGITS),
    .BLANK_CYCLES(2)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Element 0 is the frame on display; any further element is waiting.
  frame_t      exp_q[$];
  bit          running  = 1'b0;
  int unsigned t        = 0;
  bit          exp_done = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference timeline: time since the first displayed cycle decides digit and phase.
  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      exp_q.delete();
      running  = 1'b0;
      t        = 0;
      exp_done = 1'b0;
    end else begin
      exp_done = 1'b0;
      if (running) begin
        t++;
        if (t % PERIOD == 0) begin
          exp_done = 1'b1;
          if (exp_q.size() > 1) void'(exp_q.pop_front());
        end
      end
      if (bus.frame_valid && bus.frame_ready) begin
        exp_q.push_back(frame_t'{data: bus.frame_data, en: bus.frame_en});
        if (!running) begin
          running = 1'b1;
          t       = 0;
        end
      end
    end
  end

  // Monitor
  initial forever begin
    logic [3:0]  e_sel;
    logic        e_en;
    logic [3:0]  e_bin;
    logic        e_rdy;
    int unsigned pos, digit;
    frame_t      f;
    @(negedge clk);
    e_sel = 4'hF;
    e_en  = 1'b0;
    e_bin = 4'h0;
    e_rdy = 1'b1;
    if (running) begin
      f     = exp_q[0];
      pos   = t % PERIOD;
      digit = pos / SLOT;
      e_bin = f.data[digit*4 +: 4];
      e_rdy = (exp_q.size() < 2);
      if ((pos % SLOT) < DWELL && f.en[digit]) begin
        e_en         = 1'b1;
        e_sel[digit] = 1'b0;
      end
    end
    check("seg_sel",     32'(bus.seg_sel),     32'(e_sel));
    check("seg_en",      32'(bus.seg_en),      32'(e_en));
    check("bin_data",    32'(bus.bin_data),    32'(e_bin));
    check("frame_ready", 32'(bus.frame_ready), 32'(e_rdy));
    check("frame_done",  32'(bus.frame_done),  32'(exp_done));
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] d, input logic [3:0] e);
    bit ok = 1'b0;
    bus.frame_data  = d;
    bus.frame_en    = e;
    bus.frame_valid = 1'b1;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk);
      if (bus.frame_ready) begin
        ok = 1'b1;
        break;
      end
    end
    #1;
    bus.frame_valid = 1'b0;
    bus.frame_data  = 16'($urandom);
    bus.frame_en    = 4'($urandom);
    check("send_accepted", 32'(ok), 32'd1);
  endtask

  initial begin
    bit found;
    bus.frame_valid = 1'b0;
    bus.frame_data  = '0;
    bus.frame_en    = '0;
    idle(3);
    rst_n = 1'b1;

    // Dark and ready with no frame offered
    idle(30);

    // Full frame, all digits lit
    send(16'h4321, 4'hF);
    idle(3 * PERIOD);

    // Back-to-back frames mid-scan: second one must wait for the boundary
    idle(7);
    send(16'hAAAA, 4'hF);
    send(16'hBBBB, 4'hF);
    idle(2 * PERIOD + 5);

    // Partial enable pattern keeps slot timing
    send(16'h9876, 4'b0101);
    idle(2 * PERIOD + 3);

    // Randomized producer timing and content
    for (int k = 0; k < 12; k++) begin
      idle($urandom_range(0, 60));
      send(16'($urandom), 4'($urandom));
    end
    idle(2 * PERIOD);

    // Asynchronous reset in the middle of digit 2
    found = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk);
      #1;
      if (running && (t % PERIOD) == 2 * SLOT + 4) begin
        found = 1'b1;
        break;
      end
    end
    check("reach_digit2", 32'(found), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_seg_sel",     32'(bus.seg_sel),     32'hF);
    check("rst_seg_en",      32'(bus.seg_en),      32'd0);
    check("rst_frame_ready", 32'(bus.frame_ready), 32'd1);
    check("rst_bin_data",    32'(bus.bin_data),    32'd0);
    idle(3);
    rst_n = 1'b1;
    idle(40);
    send(16'h5A3C, 4'b1110);
    idle(2 * PERIOD);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
